// File: rtl/uart_cfg.sv
// uart_cfg: run-time configurable UART with FIFO-buffered RX/TX,
// 5-8 data bits, optional parity, 1/2 stop bits and error tagging.
module uart_cfg #(
    parameter int DVSR_W = 16,
    parameter int FIFO_W = 4,
    parameter int SB_OS  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic [1:0]        dbits,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              stop2,
    input  logic              wr_uart,
    input  logic [7:0]        w_data,
    input  logic              rd_uart,
    input  logic              rx,
    input  logic              clr_ovr,
    output logic              tx,
    output logic              tx_full,
    output logic              tx_busy,
    output logic [FIFO_W:0]   tx_level,
    output logic [7:0]        r_data,
    output logic              r_perr,
    output logic              r_ferr,
    output logic              rx_empty,
    output logic [FIFO_W:0]   rx_level,
    output logic              ovr
);
    localparam logic [4:0] S_MID   = 5'(SB_OS / 2 - 1);
    localparam logic [4:0] S_LAST  = 5'(SB_OS - 1);
    localparam logic [4:0] S_LAST2 = 5'(2 * SB_OS - 1);

    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA, T_PAR, T_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BRK
    } rx_state_t;

    logic [DVSR_W-1:0] tcnt;
    logic              tick;

    // >= rather than == so a reduced divisor never strands the counter
    assign tick = (tcnt >= dvsr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tcnt <= '0;
        else      tcnt <= tick ? '0 : tcnt + DVSR_W'(1);
    end

    tx_state_t  ts, ts_n;
    logic [4:0] ts_s, ts_s_n;
    logic [2:0] tn, tn_n, t_last, t_last_n;
    logic [7:0] tb, tb_n;
    logic       tp, tp_n, t_pen, t_pen_n, t_st2, t_st2_n;
    logic       tx_pop, tx_empty;
    logic [7:0] tx_head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts     <= T_IDLE;
            ts_s   <= '0;
            tn     <= '0;
            tb     <= '0;
            tp     <= 1'b0;
            t_last <= '0;
            t_pen  <= 1'b0;
            t_st2  <= 1'b0;
        end else begin
            ts     <= ts_n;
            ts_s   <= ts_s_n;
            tn     <= tn_n;
            tb     <= tb_n;
            tp     <= tp_n;
            t_last <= t_last_n;
            t_pen  <= t_pen_n;
            t_st2  <= t_st2_n;
        end
    end

    always_comb begin
        ts_n     = ts;
        ts_s_n   = ts_s;
        tn_n     = tn;
        tb_n     = tb;
        tp_n     = tp;
        t_last_n = t_last;
        t_pen_n  = t_pen;
        t_st2_n  = t_st2;
        tx_pop   = 1'b0;
        tx       = 1'b1;
        unique case (ts)
            T_IDLE: ;
            T_START: begin
                tx = 1'b0;
                if (tick) begin
                    if (ts_s == S_LAST) begin
                        ts_s_n = '0;
                        tn_n   = '0;
                        ts_n   = T_DATA;
                    end else begin
                        ts_s_n = ts_s + 5'd1;
                    end
                end
            end
            T_DATA: begin
                tx = tb[tn];
                if (tick) begin
                    if (ts_s == S_LAST) begin
                        ts_s_n = '0;
                        tp_n   = tp ^ tb[tn];
                        if (tn == t_last) ts_n = t_pen ? T_PAR : T_STOP;
                        else              tn_n = tn + 3'd1;
                    end else begin
                        ts_s_n = ts_s + 5'd1;
                    end
                end
            end
            T_PAR: begin
                tx = tp;
                if (tick) begin
                    if (ts_s == S_LAST) begin
                        ts_s_n = '0;
                        ts_n   = T_STOP;
                    end else begin
                        ts_s_n = ts_s + 5'd1;
                    end
                end
            end
            T_STOP: begin
                if (tick) begin
                    if (ts_s == (t_st2 ? S_LAST2 : S_LAST)) ts_n = T_IDLE;
                    else ts_s_n = ts_s + 5'd1;
                end
            end
            default: ts_n = T_IDLE;
        endcase
        // Loading from the end of STOP keeps back-to-back frames gapless
        if (ts_n == T_IDLE && !tx_empty) begin
            tx_pop   = 1'b1;
            tb_n     = tx_head;
            tp_n     = parity_odd;
            t_last_n = {1'b0, dbits} + 3'd4;
            t_pen_n  = parity_en;
            t_st2_n  = stop2;
            ts_s_n   = '0;
            ts_n     = T_START;
        end
    end

    assign tx_busy = (ts != T_IDLE);

    rx_state_t  rs, rs_n;
    logic [4:0] rs_s, rs_s_n;
    logic [2:0] rn, rn_n, r_last, r_last_n;
    logic [7:0] rb, rb_n;
    logic       rpar, rpar_n, rperr, rperr_n, r_pen, r_pen_n;
    logic       rx_push, rx_full, ovr_set;
    logic [9:0] rx_word, rx_head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs     <= R_IDLE;
            rs_s   <= '0;
            rn     <= '0;
            rb     <= '0;
            rpar   <= 1'b0;
            rperr  <= 1'b0;
            r_last <= '0;
            r_pen  <= 1'b0;
        end else begin
            rs     <= rs_n;
            rs_s   <= rs_s_n;
            rn     <= rn_n;
            rb     <= rb_n;
            rpar   <= rpar_n;
            rperr  <= rperr_n;
            r_last <= r_last_n;
            r_pen  <= r_pen_n;
        end
    end

    always_comb begin
        rs_n     = rs;
        rs_s_n   = rs_s;
        rn_n     = rn;
        rb_n     = rb;
        rpar_n   = rpar;
        rperr_n  = rperr;
        r_last_n = r_last;
        r_pen_n  = r_pen;
        rx_push  = 1'b0;
        rx_word  = {~rx, rperr, rb};
        unique case (rs)
            R_IDLE: begin
                if (!rx) begin
                    rs_n     = R_START;
                    rs_s_n   = '0;
                    rb_n     = '0;
                    rpar_n   = parity_odd;
                    rperr_n  = 1'b0;
                    r_last_n = {1'b0, dbits} + 3'd4;
                    r_pen_n  = parity_en;
                end
            end
            R_START: begin
                if (tick) begin
                    if (rs_s == S_MID) begin
                        rs_s_n = '0;
                        rn_n   = '0;
                        rs_n   = rx ? R_IDLE : R_DATA;
                    end else begin
                        rs_s_n = rs_s + 5'd1;
                    end
                end
            end
            R_DATA: begin
                if (tick) begin
                    if (rs_s == S_LAST) begin
                        rs_s_n   = '0;
                        rb_n[rn] = rx;
                        rpar_n   = rpar ^ rx;
                        if (rn == r_last) rs_n = r_pen ? R_PAR : R_STOP;
                        else              rn_n = rn + 3'd1;
                    end else begin
                        rs_s_n = rs_s + 5'd1;
                    end
                end
            end
            R_PAR: begin
                if (tick) begin
                    if (rs_s == S_LAST) begin
                        rs_s_n  = '0;
                        rperr_n = rx ^ rpar;
                        rs_n    = R_STOP;
                    end else begin
                        rs_s_n = rs_s + 5'd1;
                    end
                end
            end
            R_STOP: begin
                if (tick) begin
                    if (rs_s == S_LAST) begin
                        rx_push = 1'b1;
                        rs_n    = rx ? R_IDLE : R_BRK;
                    end else begin
                        rs_s_n = rs_s + 5'd1;
                    end
                end
            end
            R_BRK: if (rx) rs_n = R_IDLE;
            default: rs_n = R_IDLE;
        endcase
    end

    assign ovr_set = rx_push & rx_full & ~rd_uart;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         ovr <= 1'b0;
        else if (ovr_set) ovr <= 1'b1;
        else if (clr_ovr) ovr <= 1'b0;
    end

    uart_cfg_fifo #(.W(8), .AW(FIFO_W)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr_uart),
        .rd    (tx_pop),
        .wdata (w_data),
        .rdata (tx_head),
        .empty (tx_empty),
        .full  (tx_full),
        .level (tx_level)
    );

    uart_cfg_fifo #(.W(10), .AW(FIFO_W)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (rx_push),
        .rd    (rd_uart),
        .wdata (rx_word),
        .rdata (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .level (rx_level)
    );

    assign {r_ferr, r_perr, r_data} = rx_head;
endmodule

module uart_cfg_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic         rd,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full,
    output logic [AW:0]  level
);
    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wp, rp;
    logic          wr_ok, rd_ok;

    assign empty = (level == '0);
    assign full  = level[AW];
    assign rd_ok = rd & ~empty;
    // A read frees the slot, so a write to a full FIFO still lands
    assign wr_ok = wr & (~full | rd);
    assign rdata = mem[rp];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (wr_ok) wp <= wp + AW'(1);
            if (rd_ok) rp <= rp + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule
